// File: rtl/cond_pkg.sv
// Shared constants for the condition evaluation slice: flag bit positions
// within the adder's status word and the ARM-style condition codes.
package cond_pkg;

    typedef logic [3:0] cond_t;
    typedef logic [3:0] flags_t;

    localparam int FLAG_V = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 3;

    localparam cond_t COND_EQ = 4'h0;
    localparam cond_t COND_NE = 4'h1;
    localparam cond_t COND_CS = 4'h2;
    localparam cond_t COND_CC = 4'h3;
    localparam cond_t COND_MI = 4'h4;
    localparam cond_t COND_PL = 4'h5;
    localparam cond_t COND_VS = 4'h6;
    localparam cond_t COND_VC = 4'h7;
    localparam cond_t COND_HI = 4'h8;
    localparam cond_t COND_LS = 4'h9;
    localparam cond_t COND_GE = 4'hA;
    localparam cond_t COND_LT = 4'hB;
    localparam cond_t COND_GT = 4'hC;
    localparam cond_t COND_LE = 4'hD;
    localparam cond_t COND_AL = 4'hE;
    localparam cond_t COND_NV = 4'hF;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator: maps a flag word and a 4-bit code
// to pass/illegal. Code NV is reserved and reported as illegal.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass,
    output logic       illegal
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass    = 1'b0;
        illegal = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_eval_unit.sv
// Flag register plus a single-entry result register answering condition-code
// queries one cycle after acceptance, with saturating pass/fail statistics.
module cond_eval_unit
    import cond_pkg::*;
#(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       flags_in,
    input  logic             flags_we,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [3:0]       q_cond,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             r_pass,
    output logic             r_illegal,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic       accept;
    logic       drain;
    logic [3:0] eval_flags;
    logic       eval_pass;
    logic       eval_illegal;

    assign q_ready = !r_valid || r_ready;
    assign accept  = q_valid && q_ready;
    assign drain   = r_valid && r_ready;

    // With bypass, a same-cycle flag write is visible to the query being accepted.
    assign eval_flags = ((BYPASS != 0) && flags_we) ? flags_in : flags_q;

    cond_check u_cond_check (
        .flags   (eval_flags),
        .cond    (q_cond),
        .pass    (eval_pass),
        .illegal (eval_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (flags_we) begin
            flags_q <= flags_in;
        end
    end

    // Accept wins over drain so a drain+accept cycle refills without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pass    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (accept) begin
            r_valid   <= 1'b1;
            r_pass    <= eval_pass;
            r_illegal <= eval_illegal;
        end else if (drain) begin
            r_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (drain) begin
            if (r_pass) begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_ONE;
            end else begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/cond_eval_unit.md
Name: cond_eval_unit

Overview:
- Consumer end of the adder's 4-bit status-flag interface.
- Holds the architectural flag register, loaded from the adder's flag output.
- Accepts ARM-style 4-bit condition-code queries over a valid/ready handshake and returns pass/fail one cycle later over a second valid/ready handshake.
- Sits between the ALU/adder and the branch/predication logic of the datapath.

Parameters:
- BYPASS, 1, when 1 a query accepted in the same cycle as a flag write evaluates against the incoming flags; when 0 it evaluates against the registered (old) flags.
- CNT_W, 8, width of the saturating pass and fail statistics counters.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- flags_in  in  4  flag word from adder: bit0=V, bit1=N, bit2=Z, bit3=C
- flags_we  in  1  load flags_in into the flag register this cycle
- q_valid  in  1  condition query valid
- q_ready  out  1  unit can accept a query this cycle
- q_cond  in  4  condition code
- r_valid  out  1  result valid
- r_ready  in  1  downstream accepts the result
- r_pass  out  1  condition true
- r_illegal  out  1  query used code 4'b1111
- flags_q  out  4  current flag register, same bit order as flags_in
- pass_cnt  out  CNT_W  saturating count of passed results
- fail_cnt  out  CNT_W  saturating count of failed results, including illegal ones

Behaviour:
- Reset, synchronous: flags_q=0, r_valid=0, r_pass=0, r_illegal=0, pass_cnt=0, fail_cnt=0. Reset takes priority over every other event in that cycle, including flags_we and query acceptance. A pending result is discarded.
- Flag register: flags_q <= flags_in on any cycle with flags_we=1; otherwise it holds.
- Output register: single entry.
  - q_ready = !r_valid || r_ready. This is combinational and permits back-to-back throughput of one query per cycle.
- Query accept (q_valid && q_ready):
  - Next cycle: r_valid=1; r_pass and r_illegal are the evaluation of q_cond. Latency is exactly 1 cycle.
  - Evaluation flags are flags_in when BYPASS=1 and flags_we=1 in the accept cycle; otherwise flags_q.
- Result hold: while r_valid && !r_ready, r_valid, r_pass and r_illegal hold stable. A concurrent flags_we does not alter the held result.
- Result drain: on r_valid && r_ready with no new accept, r_valid goes to 0 next cycle. On drain plus accept in the same cycle, the new result replaces the old one with no bubble.
- Condition table (N, Z, C, V taken from the selected flags):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: r_pass=0, r_illegal=1. For every other code r_illegal=0.
- Counters:
  - Each increments once per result handshake (r_valid && r_ready): pass_cnt if r_pass, else fail_cnt.
  - Both saturate at all-ones and never wrap.
  - Only reset clears them.
- No multi-state FSM beyond the output-register valid bit: EMPTY (r_valid=0) and FULL (r_valid=1). Transitions follow the accept and drain rules above.

Decomposition:
- Shared package (cond_pkg):
  - Flag bit index constants FLAG_V=0, FLAG_N=1, FLAG_Z=2, FLAG_C=3.
  - Condition code constants COND_EQ through COND_AL and COND_NV=4'hF.
- Sub-module cond_check: purely combinational; inputs are the 4-bit flags and the 4-bit code; outputs are pass and illegal.
- cond_eval_unit instantiates cond_check once and owns the flag register, handshake and counters.

Test Plan:
- Reset mid-stream: flags_q=4'b1111 and r_valid=1 with r_ready=0, then pulse reset -> next cycle all outputs 0; q_ready=1.
- Table sweep: flags_we with flags_in=4'b0100 (Z=1), then all 16 codes back-to-back with r_ready=1 -> pass pattern 1,0,0,1,0,1,0,1,0,1,1,0,0,1,1,0; code F gives r_illegal=1; one result per cycle.
- Bypass: flags_q=0, same cycle flags_we=1, flags_in=4'b0100, query EQ -> BYPASS=1 gives r_pass=1; BYPASS=0 gives r_pass=0; flags_q=4'b0100 afterwards in both.
- Backpressure: r_ready=0 for 3 cycles after an accepted GE query with N=1, V=0 -> r_valid=1 and r_pass=0 held stable; q_ready=0; a flags_we in that window leaves r_pass unchanged; r_ready=1 drains it.
- Signed overflow link: flags_in=4'b0011 (V=1, N=1, e.g. 0111+0001 signed) -> GE pass, LT fail, VS pass, MI pass.
- Counter saturation, CNT_W=2: 5 AL results drained -> pass_cnt=3, fail_cnt=0; then one NV -> fail_cnt=1.
